// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types and helpers for the FPU compare unit
// Purpose: compare-op encoding, classified-operand struct and canonical NaN builder.
// Fields of float_class_t are sized for the widest supported format (binary64);
// narrower formats zero-extend exponent and mantissa, which preserves ordering.
package fpu_pkg;

    localparam int MAX_EXP_W = 11;
    localparam int MAX_MAN_W = 52;
    localparam int MAX_FLEN  = 1 + MAX_EXP_W + MAX_MAN_W;

    typedef enum logic [2:0] {
        FEQ  = 3'd0,
        FLT  = 3'd1,
        FLE  = 3'd2,
        FMIN = 3'd3,
        FMAX = 3'd4
    } cmp_op_t;

    typedef struct packed {
        logic                 sgn;
        logic [MAX_EXP_W-1:0] exp;
        logic [MAX_MAN_W-1:0] man;
        logic                 zero;
        logic                 inf;
        logic                 snan;
        logic                 qnan;
        logic                 subnormal;
    } float_class_t;

    // Positive quiet NaN: exponent all ones, mantissa MSB set, rest zero.
    function automatic logic [MAX_FLEN-1:0] canonical_nan(input int exp_w, input int man_w);
        logic [MAX_FLEN-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_FLEN; i++) begin
            if (i >= man_w - 1 && i < man_w + exp_w) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/float_classify.sv
// rtl/float_classify.sv - combinational split of an IEEE-754 operand into float_class_t
// Purpose: extract sign/exponent/mantissa and zero/inf/NaN/subnormal flags.
// Ports:
//   x    in   FLEN  raw operand
//   cls  out        classified operand (exponent/mantissa zero-extended)
module float_classify
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int FLEN = 1 + EXP_W + MAN_W
) (
    input  logic [FLEN-1:0] x,
    output float_class_t    cls
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             exp_ones;
    logic             exp_zero;
    logic             man_zero;
    logic             is_nan;

    assign exp_f    = x[FLEN-2:MAN_W];
    assign man_f    = x[MAN_W-1:0];
    assign exp_ones = &exp_f;
    assign exp_zero = ~|exp_f;
    assign man_zero = ~|man_f;
    assign is_nan   = exp_ones && !man_zero;

    always_comb begin
        cls           = '0;
        cls.sgn       = x[FLEN-1];
        cls.exp       = MAX_EXP_W'(exp_f);
        cls.man       = MAX_MAN_W'(man_f);
        cls.zero      = exp_zero && man_zero;
        cls.inf       = exp_ones && man_zero;
        // Mantissa MSB distinguishes quiet from signalling NaN.
        cls.qnan      = is_nan && man_f[MAN_W-1];
        cls.snan      = is_nan && !man_f[MAN_W-1];
        cls.subnormal = exp_zero && !man_zero;
    end

endmodule

// File: rtl/float_compare_unit.sv
// rtl/float_compare_unit.sv - two-stage pipelined FEQ/FLT/FLE/FMIN/FMAX unit with NV flag
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush           kill all in-flight operations
//   valid_in/ready_in   issue-side handshake; op, a, b are the operation
//   valid_out/ready_out writeback-side handshake; result, nv are the response
module float_compare_unit
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int FLEN = 1 + EXP_W + MAN_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            valid_in,
    output logic            ready_in,
    input  logic [2:0]      op,
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic            valid_out,
    input  logic            ready_out,
    output logic [FLEN-1:0] result,
    output logic            nv
);

    localparam logic [MAX_FLEN-1:0] CANON_NAN_W = canonical_nan(EXP_W, MAN_W);
    localparam logic [FLEN-1:0]     CANON_NAN   = CANON_NAN_W[FLEN-1:0];

    float_class_t    cls_a, cls_b;
    float_class_t    s1_a, s1_b;
    cmp_op_t         s1_op;
    logic            s1_valid;
    logic            s2_valid;
    logic            s2_ready;
    logic            s1_advance;
    logic            accept;
    logic [FLEN-1:0] s2_result_d;
    logic            s2_nv_d;

    float_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.x(a), .cls(cls_a));
    float_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.x(b), .cls(cls_b));

    // S2 can take a new entry when empty or when its current result leaves this cycle.
    assign s2_ready   = !s2_valid || ready_out;
    assign s1_advance = s1_valid && s2_ready;
    assign ready_in   = !s1_valid || s1_advance;
    assign accept     = valid_in && ready_in && !flush;
    assign valid_out  = s2_valid;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (ready_in) s1_valid <= valid_in;
            if (s2_ready) s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_a  <= '0;
            s1_b  <= '0;
            s1_op <= FEQ;
        end else if (accept) begin
            s1_a  <= cls_a;
            s1_b  <= cls_b;
            s1_op <= cmp_op_t'(op);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            nv     <= 1'b0;
        end else if (s1_advance) begin
            result <= s2_result_d;
            nv     <= s2_nv_d;
        end
    end

    logic [MAX_EXP_W+MAX_MAN_W-1:0] mag_a, mag_b;
    logic [FLEN-1:0] a_bits, b_bits;
    logic a_nan, b_nan, any_nan, any_snan;
    logic sgn_diff, both_zero, mag_lt, mag_gt;
    logic a_lt_b, a_gt_b, cmp_lt, cmp_eq;

    always_comb begin
        s2_result_d = '0;
        s2_nv_d     = 1'b0;

        mag_a     = {s1_a.exp, s1_a.man};
        mag_b     = {s1_b.exp, s1_b.man};
        a_bits    = {s1_a.sgn, s1_a.exp[EXP_W-1:0], s1_a.man[MAN_W-1:0]};
        b_bits    = {s1_b.sgn, s1_b.exp[EXP_W-1:0], s1_b.man[MAN_W-1:0]};
        a_nan     = s1_a.snan || s1_a.qnan;
        b_nan     = s1_b.snan || s1_b.qnan;
        any_nan   = a_nan || b_nan;
        any_snan  = s1_a.snan || s1_b.snan;
        sgn_diff  = s1_a.sgn != s1_b.sgn;
        both_zero = s1_a.zero && s1_b.zero;
        mag_lt    = mag_a < mag_b;
        mag_gt    = mag_a > mag_b;

        // Total order with -0 < +0; a larger magnitude is smaller when negative.
        a_lt_b = sgn_diff ? s1_a.sgn : (s1_a.sgn ? mag_gt : mag_lt);
        a_gt_b = sgn_diff ? s1_b.sgn : (s1_a.sgn ? mag_lt : mag_gt);
        // Compares treat the two zeros as equal.
        cmp_lt = a_lt_b && !both_zero;
        cmp_eq = both_zero || (!sgn_diff && mag_a == mag_b);

        case (s1_op)
            FEQ: begin
                s2_result_d[0] = !any_nan && cmp_eq;
                s2_nv_d        = any_snan;
            end
            FLT: begin
                s2_result_d[0] = !any_nan && cmp_lt;
                s2_nv_d        = any_nan;
            end
            FLE: begin
                s2_result_d[0] = !any_nan && (cmp_lt || cmp_eq);
                s2_nv_d        = any_nan;
            end
            FMIN: begin
                if (a_nan && b_nan)  s2_result_d = CANON_NAN;
                else if (a_nan)      s2_result_d = b_bits;
                else if (b_nan)      s2_result_d = a_bits;
                else                 s2_result_d = a_gt_b ? b_bits : a_bits;
                s2_nv_d = any_snan;
            end
            FMAX: begin
                if (a_nan && b_nan)  s2_result_d = CANON_NAN;
                else if (a_nan)      s2_result_d = b_bits;
                else if (b_nan)      s2_result_d = a_bits;
                else                 s2_result_d = a_lt_b ? b_bits : a_bits;
                s2_nv_d = any_snan;
            end
            default: ;
        endcase
    end

    logic unused_cls;
    assign unused_cls = ^{s1_a.inf, s1_a.subnormal, s1_b.inf, s1_b.subnormal};

endmodule

// File: tb/tb_float_compare_unit.sv
// tb/tb_float_compare_unit.sv - scoreboard bench for float_compare_unit (binary32)
module tb_float_compare_unit;

    localparam int FLEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            flush = 1'b0;
    logic            valid_in = 1'b0;
    logic            ready_in;
    logic [2:0]      op = 3'd0;
    logic [FLEN-1:0] a = '0;
    logic [FLEN-1:0] b = '0;
    logic            valid_out;
    logic            ready_out = 1'b0;
    logic [FLEN-1:0] result;
    logic            nv;

    always #5 clk = ~clk;

    float_compare_unit #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .valid_in(valid_in), .ready_in(ready_in), .op(op), .a(a), .b(b),
        .valid_out(valid_out), .ready_out(ready_out), .result(result), .nv(nv)
    );

    int          errors = 0;
    int          checks = 0;
    logic [32:0] exp_q[$];
    bit          rand_bp = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, want);
        end
    endtask

    // Independent reference: map floats to unsigned keys whose order is the IEEE total order.
    function automatic logic [31:0] key(input logic [31:0] x, input bit merge_zero);
        if (merge_zero && x[30:0] == 31'd0) return 32'h8000_0000;
        return x[31] ? ~x : {1'b1, x[30:0]};
    endfunction

    function automatic logic [32:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bit xn, yn, xs, ys, an, asn;
        logic [31:0] r;
        xn  = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        yn  = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        xs  = xn && !x[22];
        ys  = yn && !y[22];
        an  = xn || yn;
        asn = xs || ys;
        case (o)
            3'd0: return {asn, 31'd0, !an && key(x, 1) == key(y, 1)};
            3'd1: return {an,  31'd0, !an && key(x, 1) <  key(y, 1)};
            3'd2: return {an,  31'd0, !an && key(x, 1) <= key(y, 1)};
            3'd3, 3'd4: begin
                if (xn && yn) r = 32'h7FC0_0000;
                else if (xn)  r = y;
                else if (yn)  r = x;
                else if (o == 3'd3) r = (key(y, 0) < key(x, 0)) ? y : x;
                else                r = (key(x, 0) < key(y, 0)) ? y : x;
                return {asn, r};
            end
            default: return 33'd0;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [32:0] want);
        int n;
        valid_in = 1'b1; op = o; a = x; b = y; n = 0;
        @(negedge clk);
        while (!ready_in && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_in) check("accept_timeout", 64'(ready_in), 64'd1);
        else           exp_q.push_back(want);
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        #1;
    endtask

    // Retirement monitor
    logic [32:0] mon_e;
    always @(negedge clk) begin
        if (!reset && valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
                check("spurious_retire", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", 64'(result), 64'(mon_e[31:0]));
                check("nv", 64'(nv), 64'(mon_e[32]));
            end
        end
    end

    // Output stability while stalled
    logic        held_v = 1'b0;
    logic [32:0] held;
    always @(negedge clk) begin
        if (held_v) begin
            check("stall_valid", 64'(valid_out), 64'd1);
            check("stall_hold", 64'({nv, result}), 64'(held));
        end
        held_v = !reset && !flush && valid_out && !ready_out;
        held   = {nv, result};
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            ready_out = ($urandom_range(3) != 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    localparam int NDIR = 17;
    logic [2:0]  d_op [NDIR] = '{3'd1, 3'd2, 3'd1, 3'd0, 3'd1, 3'd3, 3'd4, 3'd0, 3'd1, 3'd0,
                                 3'd4, 3'd3, 3'd3, 3'd2, 3'd5, 3'd4, 3'd3};
    logic [31:0] d_a  [NDIR] = '{32'h3F800000, 32'hC0000000, 32'h40000000, 32'h00000000,
                                 32'h00000000, 32'h00000000, 32'h00000000, 32'h7FC00000,
                                 32'h7FC00000, 32'h7F800001, 32'h7F800001, 32'h7FC00000,
                                 32'h00000001, 32'h80000000, 32'h3F800000, 32'h80000000,
                                 32'hFF800000};
    logic [31:0] d_b  [NDIR] = '{32'h40000000, 32'hBF800000, 32'h3F800000, 32'h80000000,
                                 32'h80000000, 32'h80000000, 32'h80000000, 32'h3F800000,
                                 32'h3F800000, 32'h7F800001, 32'h40400000, 32'h7F800001,
                                 32'h00000002, 32'h00000000, 32'h40000000, 32'h00000000,
                                 32'h3F800000};
    logic [32:0] d_e  [NDIR] = '{{1'b0, 32'h1}, {1'b0, 32'h1}, {1'b0, 32'h0}, {1'b0, 32'h1},
                                 {1'b0, 32'h0}, {1'b0, 32'h80000000}, {1'b0, 32'h00000000},
                                 {1'b0, 32'h0}, {1'b1, 32'h0}, {1'b1, 32'h0},
                                 {1'b1, 32'h40400000}, {1'b1, 32'h7FC00000},
                                 {1'b0, 32'h00000001}, {1'b0, 32'h1}, {1'b0, 32'h0},
                                 {1'b0, 32'h00000000}, {1'b0, 32'hFF800000}};

    localparam int NPOOL = 12;
    logic [31:0] pool [NPOOL] = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
                                  32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800001,
                                  32'hFFC00001, 32'h00000001, 32'h80000003, 32'h40400000};

    function automatic logic [31:0] pick();
        int idx;
        idx = $urandom_range(NPOOL);
        return (idx == NPOOL) ? 32'($urandom) : pool[idx];
    endfunction

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        ready_out = 1'b1;
        @(negedge clk);
        check("reset_valid_out", 64'(valid_out), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_nv", 64'(nv), 64'd0);
        check("reset_ready_in", 64'(ready_in), 64'd1);
        @(posedge clk); #1;

        // Two-cycle latency on a single operation
        issue(3'd1, 32'h3F800000, 32'h40000000, {1'b0, 32'h1});
        @(negedge clk);
        check("latency_c1_valid", 64'(valid_out), 64'd0);
        @(negedge clk);
        check("latency_c2_valid", 64'(valid_out), 64'd1);
        @(posedge clk); #1;

        // Directed table, back to back
        for (int i = 0; i < NDIR; i++) issue(d_op[i], d_a[i], d_b[i], d_e[i]);
        drain();

        // Backpressure: 4 ops, downstream stalled
        ready_out = 1'b0;
        fork
            begin
                issue(3'd4, 32'h3F800000, 32'h40000000, {1'b0, 32'h40000000});
                issue(3'd3, 32'hBF800000, 32'h3F800000, {1'b0, 32'hBF800000});
                issue(3'd2, 32'h40400000, 32'h40400000, {1'b0, 32'h1});
                issue(3'd0, 32'h7F800001, 32'h3F800000, {1'b1, 32'h0});
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("bp_ready_in_low", 64'(ready_in), 64'd0);
                check("bp_valid_out", 64'(valid_out), 64'd1);
                repeat (2) @(posedge clk);
                #1;
                ready_out = 1'b1;
            end
        join
        drain();

        // Flush, then reset, with two ops in flight and a valid_in in the same cycle
        for (int k = 0; k < 2; k++) begin
            ready_out = 1'b0;
            issue(3'd1, 32'hBF800000, 32'h3F800000, {1'b0, 32'h1});
            issue(3'd4, 32'h00000001, 32'h00000002, {1'b0, 32'h2});
            valid_in = 1'b1; op = 3'd3; a = 32'h40000000; b = 32'h3F800000;
            if (k == 0) flush = 1'b1;
            else        reset = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0; reset = 1'b0; valid_in = 1'b0;
            exp_q.delete();
            @(negedge clk);
            check(k == 0 ? "flush_valid_out" : "reset_valid_out2", 64'(valid_out), 64'd0);
            check(k == 0 ? "flush_ready_in" : "reset_ready_in2", 64'(ready_in), 64'd1);
            ready_out = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            issue(3'd0, 32'h3F800000, 32'h3F800000, {1'b0, 32'h1});
            drain();
        end

        // Random ops against the reference model with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 80; i++) begin
            ro = 3'($urandom_range(5));
            ra = pick();
            rb = ($urandom_range(3) == 0) ? ra : pick();
            issue(ro, ra, rb, model(ro, ra, rb));
        end
        drain();
        rand_bp = 1'b0;
        @(posedge clk); #1;
        ready_out = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
